// File: rtl/scanlines_pkg.sv
// Shared types and the per-channel attenuation rule for the scanline/mask effect.
package scanlines_pkg;

    // Widest colour channel the attenuate() helper accepts; callers
    // zero-extend into it and truncate the result back to their own width.
    localparam int unsigned ATT_W = 16;

    typedef enum logic [2:0] {
        OFF    = 3'd0,
        HORIZ  = 3'd1,
        VERT   = 3'd2,
        BOTH   = 3'd3,
        GRILLE = 3'd4
    } mode_t;

    typedef enum logic [1:0] {
        STR_NONE = 2'd0,
        STR_25   = 2'd1,
        STR_50   = 2'd2,
        STR_75   = 2'd3
    } strength_t;

    // One darkening step; results never exceed x, so truncation back to the
    // caller's channel width is lossless.
    function automatic logic [ATT_W-1:0] attenuate(input logic [ATT_W-1:0] x,
                                                   input strength_t s);
        logic [ATT_W-1:0] r;
        r = x;
        case (s)
            STR_25:  r = x - (x >> 2);
            STR_50:  r = x >> 1;
            STR_75:  r = x >> 2;
            default: r = x;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/scanlines_attenuator.sv
// One colour channel: pass, attenuate once, or attenuate twice (cascade).
module scanlines_attenuator
    import scanlines_pkg::*;
#(
    parameter int unsigned CW = 8
) (
    input  logic [CW-1:0] x_i,
    input  strength_t     str_i,
    input  logic          en_i,
    input  logic          cascade_i,
    output logic [CW-1:0] y_o
);

    logic [CW-1:0] once;
    logic [CW-1:0] twice;

    // Select between the raw, single and double attenuated channel value.
    always_comb begin
        once  = CW'(attenuate(ATT_W'(x_i), str_i));
        twice = CW'(attenuate(ATT_W'(once), str_i));
        y_o   = x_i;
        if (en_i) begin
            y_o = cascade_i ? twice : once;
        end
    end

endmodule

// File: rtl/scanlines_mask.sv
// CRT scanline / column / aperture-grille darkening with frame-shadowed
// configuration and a fixed two-cycle pipeline on video and sync.
module scanlines_mask
    import scanlines_pkg::*;
#(
    parameter int unsigned CW = 8,
    parameter int unsigned PW = 3
) (
    input  logic            clk_vid,
    input  logic            reset_n,
    input  logic [2:0]      mode,
    input  logic [1:0]      strength,
    input  logic [PW-1:0]   period,
    input  logic [PW-1:0]   thickness,
    input  logic            alt_field,
    input  logic [3*CW-1:0] core_rgb,
    input  logic            core_hs,
    input  logic            core_vs,
    input  logic            core_de,
    output logic [3*CW-1:0] scnl_rgb,
    output logic            scnl_hs,
    output logic            scnl_vs,
    output logic            scnl_de
);

    // Edge detection history
    logic            vs_prev_q, de_prev_q;
    // Frame-shadowed configuration
    logic [2:0]      mode_q, mode_d;
    strength_t       str_q, str_d;
    logic [PW-1:0]   per_q, per_d;
    logic [PW-1:0]   thk_q, thk_d;
    logic            alt_q, alt_d;
    // Phase state
    logic            parity_q, parity_d;
    logic [PW-1:0]   line_q, line_d;
    logic [PW-1:0]   pix_q, pix_d;
    logic [1:0]      grille_q, grille_d;
    // Stage 1 (video + per-channel decision)
    logic [3*CW-1:0] rgb_s1_q, rgb_s1_d;
    logic            hs_s1_q, vs_s1_q, de_s1_q;
    strength_t       str_s1_q;
    logic [2:0]      en_s1_q, en_d;
    logic [2:0]      casc_s1_q, casc_d;
    // Stage 2 (outputs)
    logic [3*CW-1:0] rgb_o_q, rgb_o_d;
    logic            hs_o_q, vs_o_q, de_o_q;

    logic            vs_rise, de_fall;
    logic [PW-1:0]   per_eff;
    logic            line_last, pix_last;
    logic            dark_h, dark_v;
    mode_t           act_mode;

    // Next-state for shadow config, phase counters and the darkening decision.
    always_comb begin
        vs_rise   = core_vs & ~vs_prev_q;
        de_fall   = ~core_de & de_prev_q;
        per_eff   = (per_q < PW'(2)) ? PW'(2) : per_q;
        line_last = (line_q >= per_eff - PW'(1));
        pix_last  = (pix_q >= per_eff - PW'(1));

        mode_d   = mode_q;
        str_d    = str_q;
        per_d    = per_q;
        thk_d    = thk_q;
        alt_d    = alt_q;
        parity_d = parity_q;
        line_d   = line_q;

        if (vs_rise) begin
            mode_d   = mode;
            str_d    = strength_t'(strength);
            per_d    = period;
            thk_d    = thickness;
            alt_d    = alt_field;
            parity_d = ~parity_q;
            // Load value is 0 or 1, already below any effective period (>= 2).
            line_d   = (alt_field & ~parity_q) ? PW'(1) : '0;
        end else if (de_fall) begin
            line_d = line_last ? '0 : line_q + PW'(1);
        end

        pix_d    = '0;
        grille_d = '0;
        if (core_de) begin
            pix_d    = pix_last ? '0 : pix_q + PW'(1);
            grille_d = (grille_q == 2'd2) ? '0 : grille_q + 2'd1;
        end

        dark_h   = (line_q < thk_q);
        dark_v   = (pix_q < thk_q);
        act_mode = (mode_q > 3'd4) ? OFF : mode_t'(mode_q);

        // Bit 2 = R, bit 1 = G, bit 0 = B, matching the RGB bus order.
        en_d   = '0;
        casc_d = '0;
        case (act_mode)
            HORIZ: en_d = {3{dark_h}};
            VERT:  en_d = {3{dark_v}};
            BOTH: begin
                en_d   = {3{dark_h | dark_v}};
                casc_d = {3{dark_h & dark_v}};
            end
            GRILLE: begin
                case (grille_q)
                    2'd0:    en_d = 3'b011;
                    2'd1:    en_d = 3'b101;
                    2'd2:    en_d = 3'b110;
                    default: en_d = 3'b111;
                endcase
            end
            default: en_d = '0;
        endcase

        rgb_s1_d = core_de ? core_rgb : '0;
    end

    // Shadow config, parity and phase counter registers.
    always_ff @(posedge clk_vid or negedge reset_n) begin
        if (!reset_n) begin
            vs_prev_q <= 1'b0;
            de_prev_q <= 1'b0;
            mode_q    <= '0;
            str_q     <= STR_NONE;
            per_q     <= '0;
            thk_q     <= '0;
            alt_q     <= 1'b0;
            parity_q  <= 1'b0;
            line_q    <= '0;
            pix_q     <= '0;
            grille_q  <= '0;
        end else begin
            vs_prev_q <= core_vs;
            de_prev_q <= core_de;
            mode_q    <= mode_d;
            str_q     <= str_d;
            per_q     <= per_d;
            thk_q     <= thk_d;
            alt_q     <= alt_d;
            parity_q  <= parity_d;
            line_q    <= line_d;
            pix_q     <= pix_d;
            grille_q  <= grille_d;
        end
    end

    // Stage 1: registered video, sync and per-channel attenuation controls.
    always_ff @(posedge clk_vid or negedge reset_n) begin
        if (!reset_n) begin
            rgb_s1_q  <= '0;
            hs_s1_q   <= 1'b0;
            vs_s1_q   <= 1'b0;
            de_s1_q   <= 1'b0;
            str_s1_q  <= STR_NONE;
            en_s1_q   <= '0;
            casc_s1_q <= '0;
        end else begin
            rgb_s1_q  <= rgb_s1_d;
            hs_s1_q   <= core_hs;
            vs_s1_q   <= core_vs;
            de_s1_q   <= core_de;
            str_s1_q  <= str_q;
            en_s1_q   <= en_d;
            casc_s1_q <= casc_d;
        end
    end

    scanlines_attenuator #(.CW(CW)) u_att_r (
        .x_i       (rgb_s1_q[3*CW-1:2*CW]),
        .str_i     (str_s1_q),
        .en_i      (en_s1_q[2]),
        .cascade_i (casc_s1_q[2]),
        .y_o       (rgb_o_d[3*CW-1:2*CW])
    );

    scanlines_attenuator #(.CW(CW)) u_att_g (
        .x_i       (rgb_s1_q[2*CW-1:CW]),
        .str_i     (str_s1_q),
        .en_i      (en_s1_q[1]),
        .cascade_i (casc_s1_q[1]),
        .y_o       (rgb_o_d[2*CW-1:CW])
    );

    scanlines_attenuator #(.CW(CW)) u_att_b (
        .x_i       (rgb_s1_q[CW-1:0]),
        .str_i     (str_s1_q),
        .en_i      (en_s1_q[0]),
        .cascade_i (casc_s1_q[0]),
        .y_o       (rgb_o_d[CW-1:0])
    );

    // Stage 2: attenuated video and delayed sync into the output registers.
    always_ff @(posedge clk_vid or negedge reset_n) begin
        if (!reset_n) begin
            rgb_o_q <= '0;
            hs_o_q  <= 1'b0;
            vs_o_q  <= 1'b0;
            de_o_q  <= 1'b0;
        end else begin
            rgb_o_q <= rgb_o_d;
            hs_o_q  <= hs_s1_q;
            vs_o_q  <= vs_s1_q;
            de_o_q  <= de_s1_q;
        end
    end

    assign scnl_rgb = rgb_o_q;
    assign scnl_hs  = hs_o_q;
    assign scnl_vs  = vs_o_q;
    assign scnl_de  = de_o_q;

endmodule

// File: tb/tb_scanlines_mask.sv
// Self-checking bench for scanlines_mask: table vectors, hand sequences and
// randomized frames against a frame/line/pixel-index reference model.
module tb_scanlines_mask;

    localparam int unsigned CW = 8;
    localparam int unsigned PW = 3;
    localparam int LLEN = 5;

    logic          clk_vid = 1'b0;
    logic          reset_n = 1'b0;
    logic [2:0]    cfg_mode = '0;
    logic [1:0]    cfg_str = '0;
    logic [2:0]    cfg_per = '0;
    logic [2:0]    cfg_thk = '0;
    logic          cfg_alt = 1'b0;
    logic [23:0]   core_rgb = '0;
    logic          core_hs = 1'b0, core_vs = 1'b0, core_de = 1'b0;
    logic [23:0]   scnl_rgb;
    logic          scnl_hs, scnl_vs, scnl_de;

    int total = 0;
    int bad = 0;

    always #5 clk_vid = ~clk_vid;

    scanlines_mask #(.CW(CW), .PW(PW)) dut (
        .clk_vid   (clk_vid),
        .reset_n   (reset_n),
        .mode      (cfg_mode),
        .strength  (cfg_str),
        .period    (cfg_per),
        .thickness (cfg_thk),
        .alt_field (cfg_alt),
        .core_rgb  (core_rgb),
        .core_hs   (core_hs),
        .core_vs   (core_vs),
        .core_de   (core_de),
        .scnl_rgb  (scnl_rgb),
        .scnl_hs   (scnl_hs),
        .scnl_vs   (scnl_vs),
        .scnl_de   (scnl_de)
    );

    // ---------------- reference model ----------------
    logic [2:0] m_mode, m_per, m_thk;
    logic [1:0] m_str;
    logic       m_alt, m_par, m_pvs, m_pde;
    int         m_start, m_line, m_pix;

    typedef struct {
        logic [23:0] rgb;
        logic        hs, vs, de;
        int          tag;
    } exp_t;

    exp_t        e_prev;
    logic [23:0] cap [1:4];
    bit          rand_rgb = 0;
    logic [23:0] fixed_rgb = '0;

    function automatic int att(input int x, input logic [1:0] s);
        case (s)
            2'd1:    return x - x / 4;
            2'd2:    return x / 2;
            2'd3:    return x / 4;
            default: return x;
        endcase
    endfunction

    task automatic model_reset();
        m_mode = '0; m_str = '0; m_per = '0; m_thk = '0; m_alt = 1'b0;
        m_par = 1'b0; m_pvs = 1'b0; m_pde = 1'b0;
        m_start = 0; m_line = 0; m_pix = 0;
        e_prev = '{rgb: '0, hs: 1'b0, vs: 1'b0, de: 1'b0, tag: 0};
    endtask

    // Expected output pixel for the pixel presented this cycle.
    function automatic logic [23:0] model_rgb(input logic [23:0] rgb, input logic de);
        int p, lp, pp, n, x;
        bit h, v;
        logic [23:0] r;
        logic [7:0] ch;
        if (!de) return '0;
        p  = (m_per < 3'd2) ? 2 : int'(m_per);
        lp = (m_start + m_line) % p;
        pp = m_pix % p;
        h  = (lp < int'(m_thk));
        v  = (pp < int'(m_thk));
        r  = '0;
        for (int c = 0; c < 3; c++) begin
            ch = rgb[23 - 8*c -: 8];
            x  = int'(ch);
            case (m_mode)
                3'd1:    n = int'(h);
                3'd2:    n = int'(v);
                3'd3:    n = int'(h) + int'(v);
                3'd4:    n = ((m_pix % 3) == c) ? 0 : 1;
                default: n = 0;
            endcase
            for (int k = 0; k < n; k++) x = att(x, m_str);
            r[23 - 8*c -: 8] = x[7:0];
        end
        return r;
    endfunction

    task automatic model_step(input logic vs, input logic de);
        if (vs && !m_pvs) begin
            m_mode = cfg_mode; m_str = cfg_str; m_per = cfg_per;
            m_thk = cfg_thk;   m_alt = cfg_alt;
            m_par = ~m_par;
            m_start = (cfg_alt && m_par) ? 1 : 0;
            m_line = 0;
        end else if (!de && m_pde) begin
            m_line++;
        end
        m_pix = de ? m_pix + 1 : 0;
        m_pvs = vs;
        m_pde = de;
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [26:0] got, input logic [26:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h required %h at %0t", name, got, want, $time);
        end
    endtask

    // One clock: drive at negedge, model at posedge, compare previous pixel.
    task automatic cycle(input logic [23:0] rgb, input logic hs, input logic vs,
                         input logic de, input int tag);
        exp_t e_now;
        core_rgb = rgb; core_hs = hs; core_vs = vs; core_de = de;
        e_now.rgb = model_rgb(rgb, de);
        e_now.hs = hs; e_now.vs = vs; e_now.de = de; e_now.tag = tag;
        @(posedge clk_vid);
        model_step(vs, de);
        @(negedge clk_vid);
        check("pipe", {scnl_de, scnl_vs, scnl_hs, scnl_rgb},
              {e_prev.de, e_prev.vs, e_prev.hs, e_prev.rgb});
        if (e_prev.tag > 0) cap[e_prev.tag] = scnl_rgb;
        e_prev = e_now;
    endtask

    task automatic pixel_src(output logic [23:0] px);
        px = rand_rgb ? 24'($urandom) : fixed_rgb;
    endtask

    // A frame: vs pulse with de low, then nlines lines of llen pixels.
    task automatic run_frame(input int nlines, input int llen, input int tl,
                             input int tp, input int slot, input bit scramble);
        logic [23:0] px;
        cycle('0, 1'b0, 1'b1, 1'b0, 0);
        cycle('0, 1'b0, 1'b1, 1'b0, 0);
        cycle('0, 1'b0, 1'b0, 1'b0, 0);
        for (int l = 0; l < nlines; l++) begin
            if (scramble && l == 1) begin
                cfg_mode = 3'($urandom); cfg_str = 2'($urandom);
                cfg_per = 3'($urandom); cfg_thk = 3'($urandom); cfg_alt = 1'($urandom);
            end
            for (int p = 0; p < llen; p++) begin
                pixel_src(px);
                cycle(px, 1'b0, 1'b0, 1'b1, (l == tl && p == tp) ? slot : 0);
            end
            cycle('0, 1'b1, 1'b0, 1'b0, 0);
            cycle('0, 1'b0, 1'b0, 1'b0, 0);
        end
    endtask

    task automatic set_cfg(input logic [2:0] md, input logic [1:0] st, input logic [2:0] pe,
                           input logic [2:0] th, input logic al);
        cfg_mode = md; cfg_str = st; cfg_per = pe; cfg_thk = th; cfg_alt = al;
    endtask

    typedef struct {
        logic [2:0]  mode;
        logic [1:0]  str;
        logic [2:0]  per;
        logic [2:0]  thk;
        logic [23:0] rgb;
        int          tl;
        int          tp;
        logic [23:0] want;
    } vec_t;

    vec_t vt [18];

    initial begin
        logic [23:0] px;
        vt[0]  = '{3'd1, 2'd2, 3'd3, 3'd1, 24'hF0F0F0, 0, 2, 24'h787878};
        vt[1]  = '{3'd1, 2'd2, 3'd3, 3'd1, 24'hF0F0F0, 1, 2, 24'hF0F0F0};
        vt[2]  = '{3'd1, 2'd2, 3'd3, 3'd1, 24'hF0F0F0, 3, 1, 24'h787878};
        vt[3]  = '{3'd3, 2'd2, 3'd2, 3'd1, 24'hFFFFFF, 0, 0, 24'h3F3F3F};
        vt[4]  = '{3'd3, 2'd2, 3'd2, 3'd1, 24'hFFFFFF, 0, 1, 24'h7F7F7F};
        vt[5]  = '{3'd3, 2'd2, 3'd2, 3'd1, 24'hFFFFFF, 1, 1, 24'hFFFFFF};
        vt[6]  = '{3'd3, 2'd2, 3'd2, 3'd1, 24'hFFFFFF, 1, 0, 24'h7F7F7F};
        vt[7]  = '{3'd4, 2'd3, 3'd3, 3'd1, 24'hFFFFFF, 0, 0, 24'hFF3F3F};
        vt[8]  = '{3'd4, 2'd3, 3'd3, 3'd1, 24'hFFFFFF, 0, 1, 24'h3FFF3F};
        vt[9]  = '{3'd4, 2'd3, 3'd3, 3'd1, 24'hFFFFFF, 0, 2, 24'h3F3FFF};
        vt[10] = '{3'd4, 2'd3, 3'd3, 3'd1, 24'hFFFFFF, 0, 3, 24'hFF3F3F};
        vt[11] = '{3'd4, 2'd3, 3'd3, 3'd1, 24'hFFFFFF, 1, 0, 24'hFF3F3F};
        vt[12] = '{3'd1, 2'd2, 3'd0, 3'd1, 24'hF0F0F0, 2, 0, 24'h787878};
        vt[13] = '{3'd1, 2'd2, 3'd0, 3'd1, 24'hF0F0F0, 1, 0, 24'hF0F0F0};
        vt[14] = '{3'd1, 2'd1, 3'd2, 3'd1, 24'h80FF03, 0, 3, 24'h60C003};
        vt[15] = '{3'd5, 2'd3, 3'd2, 3'd1, 24'h123456, 0, 0, 24'h123456};
        vt[16] = '{3'd2, 2'd3, 3'd3, 3'd7, 24'h804020, 1, 2, 24'h201008};
        vt[17] = '{3'd3, 2'd3, 3'd2, 3'd1, 24'hFFFFFF, 0, 0, 24'h0F0F0F};

        model_reset();

        // Reset: outputs held at zero whatever the inputs do.
        set_cfg(3'd3, 2'd2, 3'd2, 3'd1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            core_rgb = 24'($urandom); core_hs = 1'b1; core_vs = 1'b0; core_de = 1'b1;
            @(negedge clk_vid);
            check("reset_out", {scnl_de, scnl_vs, scnl_hs, scnl_rgb}, '0);
        end
        reset_n = 1'b1;

        // Passthrough before the first vs_rise despite mode=3 on the pins.
        rand_rgb = 1;
        for (int i = 0; i < 12; i++) begin
            pixel_src(px);
            cycle(px, 1'($urandom), 1'b0, (i % 6) != 5, 0);
        end
        rand_rgb = 0;

        // Table-driven single-pixel checks.
        foreach (vt[i]) begin
            set_cfg(vt[i].mode, vt[i].str, vt[i].per, vt[i].thk, 1'b0);
            fixed_rgb = vt[i].rgb;
            cap[1] = 'x;
            run_frame(vt[i].tl + 1, LLEN, vt[i].tl, vt[i].tp, 1, 1'b0);
            check($sformatf("vec%0d", i), {3'b0, cap[1]}, {3'b0, vt[i].want});
        end

        // Alternating field: line 0 flips between dark and light on
        // consecutive frames.
        set_cfg(3'd1, 2'd2, 3'd2, 3'd1, 1'b1);
        fixed_rgb = 24'hF0F0F0;
        cap[1] = 'x; cap[2] = 'x;
        run_frame(2, LLEN, 0, 1, 1, 1'b0);
        run_frame(2, LLEN, 0, 1, 2, 1'b0);
        check("alt_flip",
              {26'b0, (cap[1] === 24'h787878 && cap[2] === 24'hF0F0F0) ||
                      (cap[1] === 24'hF0F0F0 && cap[2] === 24'h787878)},
              27'd1);

        // Mid-frame config write: invisible until the next vs_rise.
        set_cfg(3'd1, 2'd2, 3'd2, 3'd1, 1'b0);
        cap[1] = 'x; cap[2] = 'x;
        cycle('0, 1'b0, 1'b1, 1'b0, 0);
        cycle('0, 1'b0, 1'b0, 1'b0, 0);
        for (int l = 0; l < 3; l++) begin
            if (l == 1) set_cfg(3'd0, 2'd0, 3'd2, 3'd0, 1'b0);
            for (int p = 0; p < LLEN; p++)
                cycle(fixed_rgb, 1'b0, 1'b0, 1'b1, (l == 2 && p == 0) ? 1 : 0);
            cycle('0, 1'b0, 1'b0, 1'b0, 0);
        end
        run_frame(1, LLEN, 0, 0, 2, 1'b0);
        check("midframe_hold", {3'b0, cap[1]}, {3'b0, 24'h787878});
        check("next_frame_new", {3'b0, cap[2]}, {3'b0, 24'hF0F0F0});

        // vs_rise in the same cycle as de-fall: line phase is the load value.
        set_cfg(3'd1, 2'd2, 3'd3, 3'd1, 1'b0);
        cap[1] = 'x; cap[2] = 'x;
        for (int p = 0; p < LLEN; p++) cycle(fixed_rgb, 1'b0, 1'b0, 1'b1, 0);
        cycle('0, 1'b0, 1'b1, 1'b0, 0);
        cycle('0, 1'b0, 1'b1, 1'b0, 0);
        cycle('0, 1'b0, 1'b0, 1'b0, 0);
        for (int l = 0; l < 2; l++) begin
            for (int p = 0; p < LLEN; p++)
                cycle(fixed_rgb, 1'b0, 1'b0, 1'b1, (p == 0) ? l + 1 : 0);
            cycle('0, 1'b0, 1'b0, 1'b0, 0);
        end
        check("coinc_line0", {3'b0, cap[1]}, {3'b0, 24'h787878});
        check("coinc_line1", {3'b0, cap[2]}, {3'b0, 24'hF0F0F0});

        // Randomized frames, with random mid-frame config writes.
        rand_rgb = 1;
        for (int f = 0; f < 10; f++) begin
            set_cfg(3'($urandom), 2'($urandom), 3'($urandom), 3'($urandom), 1'($urandom));
            run_frame($urandom_range(2, 6), $urandom_range(3, 9), -1, -1, 0, 1'b1);
        end

        // Reset asserted mid-line clears outputs immediately.
        set_cfg(3'd3, 2'd3, 3'd2, 3'd1, 1'b0);
        run_frame(1, LLEN, -1, -1, 0, 1'b0);
        for (int p = 0; p < 3; p++) begin
            pixel_src(px);
            cycle(px, 1'b0, 1'b0, 1'b1, 0);
        end
        core_rgb = 24'hFFFFFF; core_de = 1'b1;
        #1 reset_n = 1'b0;
        #1 check("async_reset", {scnl_de, scnl_vs, scnl_hs, scnl_rgb}, '0);
        @(negedge clk_vid);
        @(negedge clk_vid);
        reset_n = 1'b1;
        model_reset();
        for (int i = 0; i < 10; i++) begin
            pixel_src(px);
            cycle(px, 1'b0, 1'b0, i < 7, 0);
        end
        for (int f = 0; f < 6; f++) begin
            set_cfg(3'($urandom), 2'($urandom), 3'($urandom), 3'($urandom), 1'($urandom));
            run_frame($urandom_range(2, 6), $urandom_range(3, 9), -1, -1, 0, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
